reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Turns a bouncy asynchronous push-button into a clean, fixed-length active-low
// reset pulse for a Z80 CPU. An optional watchdog can force the same pulse when
// the CPU stops refreshing it.
//
// Optional feature macro: RESET_SEQUENCER_WDT_EN
//   defined   -> watchdog counter and sticky o_wdt_fired flag are built in
//   undefined -> no watchdog logic, o_wdt_fired tied 0, i_wdt_kick ignored
//   Both builds have the same port list.
//
// Parameters
//   DEBOUNCE_COUNT / DEBOUNCE_WIDTH : cycles the synchronized button must stay
//                                     low before a pulse (>= 1), counter width
//   PULSE_COUNT    / PULSE_WIDTH    : exact CPU reset pulse length (>= 1), width
//   WDT_COUNT      / WDT_WIDTH      : watchdog timeout in cycles, counter width
//
// Ports
//   i_clk         : system clock
//   i_reset_n     : asynchronous active-low reset (from the power-on reset)
//   i_button_n    : asynchronous push-button, low = pressed
//   i_wdt_kick    : single-cycle watchdog refresh
//   o_cpu_reset_n : Z80 RESET line, active-low
//   o_busy        : high while the sequencer is not idle
//   o_wdt_fired   : sticky, set when a watchdog timeout issued a pulse
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int unsigned               DEBOUNCE_WIDTH = 16,
    parameter logic [DEBOUNCE_WIDTH-1:0] DEBOUNCE_COUNT = 16'd50_000,
    parameter int unsigned               PULSE_WIDTH    = 8,
    parameter logic [PULSE_WIDTH-1:0]    PULSE_COUNT    = 8'd100,
    parameter int unsigned               WDT_WIDTH      = 26,
    parameter logic [WDT_WIDTH-1:0]      WDT_COUNT      = 26'd50_000_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_button_n,
    input  logic i_wdt_kick,
    output logic o_cpu_reset_n,
    output logic o_busy,
    output logic o_wdt_fired
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PULSE    = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [DEBOUNCE_WIDTH-1:0] DEB_LAST   = DEBOUNCE_COUNT - DEBOUNCE_WIDTH'(1);
    localparam logic [PULSE_WIDTH-1:0]    PULSE_LAST = PULSE_COUNT - PULSE_WIDTH'(1);

    state_t                    state_q, state_d;
    logic                      btn_meta_q;
    logic                      btn_sync_q;
    logic [DEBOUNCE_WIDTH-1:0] deb_cnt_q, deb_cnt_d;
    logic [PULSE_WIDTH-1:0]    pulse_cnt_q, pulse_cnt_d;
    logic                      wdt_expire_s;

    // Two-flop synchronizer for the push-button; idles high (released).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
        end else begin
            btn_meta_q <= i_button_n;
            btn_sync_q <= btn_meta_q;
        end
    end

`ifdef RESET_SEQUENCER_WDT_EN
    localparam logic [WDT_WIDTH-1:0] WDT_LAST = WDT_COUNT - WDT_WIDTH'(1);

    logic [WDT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;
    logic                 wdt_fired_q, wdt_fired_d;

    // Watchdog next state: a kick in the expiry cycle wins; PULSE holds it at 0.
    always_comb begin
        wdt_cnt_d    = wdt_cnt_q;
        wdt_fired_d  = wdt_fired_q;
        wdt_expire_s = 1'b0;
        if (state_q != ST_PULSE && !i_wdt_kick && wdt_cnt_q == WDT_LAST) begin
            wdt_expire_s = 1'b1;
        end else begin
            wdt_expire_s = 1'b0;
        end
        if (i_wdt_kick || state_q == ST_PULSE || wdt_expire_s) begin
            wdt_cnt_d = {WDT_WIDTH{1'b0}};
        end else begin
            wdt_cnt_d = wdt_cnt_q + WDT_WIDTH'(1);
        end
        if (wdt_expire_s) begin
            wdt_fired_d = 1'b1;
        end else begin
            wdt_fired_d = wdt_fired_q;
        end
    end

    // Watchdog counter and sticky fired flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wdt_cnt_q   <= {WDT_WIDTH{1'b0}};
            wdt_fired_q <= 1'b0;
        end else begin
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_fired_q <= wdt_fired_d;
        end
    end

    assign o_wdt_fired = wdt_fired_q;
`else
    logic                 unused_kick_s;
    logic [WDT_WIDTH-1:0] unused_wdt_count_s;

    assign unused_kick_s      = i_wdt_kick;
    assign unused_wdt_count_s = WDT_COUNT;
    assign wdt_expire_s       = 1'b0;
    assign o_wdt_fired        = 1'b0;
`endif

    // FSM next state and counters; a watchdog expiry overrides any state.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = {DEBOUNCE_WIDTH{1'b0}};
        pulse_cnt_d = {PULSE_WIDTH{1'b0}};
        if (wdt_expire_s) begin
            state_d = ST_PULSE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!btn_sync_q) begin
                        state_d = ST_DEBOUNCE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (btn_sync_q) begin
                        state_d = ST_IDLE;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_d = ST_PULSE;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEBOUNCE_WIDTH'(1);
                    end
                end
                ST_PULSE: begin
                    if (pulse_cnt_q == PULSE_LAST) begin
                        // A still-held button parks in RELEASE so it cannot retrigger.
                        if (!btn_sync_q) begin
                            state_d = ST_RELEASE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + PULSE_WIDTH'(1);
                    end
                end
                ST_RELEASE: begin
                    if (btn_sync_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            deb_cnt_q   <= {DEBOUNCE_WIDTH{1'b0}};
            pulse_cnt_q <= {PULSE_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    // Decoded straight from the state register so the CPU sees no extra latency;
    // ANDing with i_reset_n keeps the CPU in reset while the block itself is.
    assign o_cpu_reset_n = i_reset_n & (state_q != ST_PULSE);
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    logic clk;
    logic i_reset_n;
    logic i_button_n;
    logic i_wdt_kick;
    logic o_cpu_reset_n;
    logic o_busy;
    logic o_wdt_fired;

    int n_vec;
    int n_err;
    int cyc;
    bit kick_en;

    reset_sequencer #(
        .DEBOUNCE_COUNT(16'd4),
        .PULSE_COUNT   (8'd3),
        .WDT_COUNT     (26'd20)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (i_reset_n),
        .i_button_n   (i_button_n),
        .i_wdt_kick   (i_wdt_kick),
        .o_cpu_reset_n(o_cpu_reset_n),
        .o_busy       (o_busy),
        .o_wdt_fired  (o_wdt_fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    // While kick_en is set a refresh is issued every 8 cycles so long tests
    // never trip the watchdog.
    task automatic step();
        @(posedge clk);
        #1;
        if (kick_en) begin
            i_wdt_kick = ((cyc % 8) == 7);
        end
        cyc++;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        #1;
        chk("rst_cpu_reset_n", o_cpu_reset_n, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_wdt_fired", o_wdt_fired, 1'b0);
        step();
        step();
        i_reset_n = 1'b1;
        #1;
    endtask

    // Button falls, held for 'hold' cycles: busy from cycle 3, pulse on 7..9,
    // idle again 3 cycles after release.
    task automatic press_check(input int hold);
        i_button_n = 1'b0;
        for (int k = 1; k <= hold + 4; k++) begin
            step();
            chk($sformatf("press%0d_rst_k%0d", hold, k), o_cpu_reset_n, !(k >= 7 && k <= 9));
            chk($sformatf("press%0d_busy_k%0d", hold, k), o_busy, (k >= 3 && k <= hold + 2));
            if (k == hold) i_button_n = 1'b1;
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        kick_en    = 1'b1;
        i_reset_n  = 1'b0;
        i_button_n = 1'b1;
        i_wdt_kick = 1'b0;

        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_busy", o_busy, 1'b0);
            chk("idle_rst", o_cpu_reset_n, 1'b1);
        end

        // Normal press, and a long hold that must not retrigger
        press_check(10);
        press_check(25);

        // Bounce: 3 low / 1 high, five times; never reaches the debounce count
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                i_button_n = (k == 3);
                step();
                chk("bounce_rst", o_cpu_reset_n, 1'b1);
            end
        end
        i_button_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("bounce_idle", o_busy, 1'b0);
        chk("bounce_rst_end", o_cpu_reset_n, 1'b1);

        // Reset asserted during the second PULSE cycle
        i_button_n = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k >= 7) chk("mp_pulse_rst", o_cpu_reset_n, 1'b0);
        end
        i_reset_n  = 1'b0;
        i_button_n = 1'b1;
        #1;
        chk("mp_async_busy", o_busy, 1'b0);
        chk("mp_async_rst", o_cpu_reset_n, 1'b0);
        step();
        chk("mp_hold_busy", o_busy, 1'b0);
        chk("mp_hold_rst", o_cpu_reset_n, 1'b0);
        step();
        chk("mp_hold2_rst", o_cpu_reset_n, 1'b0);
        i_reset_n = 1'b1;
        #1;
        chk("mp_release_rst", o_cpu_reset_n, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mp_after_busy", o_busy, 1'b0);
            chk("mp_after_rst", o_cpu_reset_n, 1'b1);
        end

        // Reset asserted mid-debounce
        i_button_n = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        chk("md_debounce_busy", o_busy, 1'b1);
        i_reset_n  = 1'b0;
        i_button_n = 1'b1;
        #1;
        chk("md_async_busy", o_busy, 1'b0);
        step();
        i_reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("md_after_busy", o_busy, 1'b0);
            chk("md_after_rst", o_cpu_reset_n, 1'b1);
        end

        kick_en    = 1'b0;
        i_wdt_kick = 1'b0;
`ifdef RESET_SEQUENCER_WDT_EN
        // No kick: counter hits 19 in the cycle before edge 20, pulse on 20..22
        do_reset();
        for (int k = 1; k <= 23; k++) begin
            step();
            chk($sformatf("wdt_rst_k%0d", k), o_cpu_reset_n, !(k >= 20 && k <= 22));
            chk($sformatf("wdt_fired_k%0d", k), o_wdt_fired, (k >= 20));
        end
        chk("wdt_idle_after", o_busy, 1'b0);

        // Kick every 10 cycles: never expires
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            step();
            chk("kick10_rst", o_cpu_reset_n, 1'b1);
            i_wdt_kick = ((k % 10) == 9);
        end
        i_wdt_kick = 1'b0;
        chk("kick10_fired", o_wdt_fired, 1'b0);

        // Kick exactly in the expiry cycle: no pulse then, next expiry at 40
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step();
            chk($sformatf("kickexp_rst_k%0d", k), o_cpu_reset_n, (k != 40));
            i_wdt_kick = (k == 19);
        end
        chk("kickexp_fired", o_wdt_fired, 1'b1);

        // Expiry during DEBOUNCE: pulse 20..22 instead of 22..24, then RELEASE
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k >= 17) begin
                chk($sformatf("wdtdeb_rst_k%0d", k), o_cpu_reset_n, !(k >= 20 && k <= 22));
                chk($sformatf("wdtdeb_busy_k%0d", k), o_busy, (k >= 18 && k <= 37));
            end
            if (k == 15) i_button_n = 1'b0;
            if (k == 35) i_button_n = 1'b1;
        end
        chk("wdtdeb_fired", o_wdt_fired, 1'b1);
`else
        // No watchdog built: long idle without kicks never pulses
        do_reset();
        for (int k = 1; k <= 45; k++) begin
            step();
            chk("nowdt_rst", o_cpu_reset_n, 1'b1);
            chk("nowdt_fired", o_wdt_fired, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
